// File: rtl/inst_fetch.sv
// inst_fetch: single-slot instruction fetch with redirect handling and an optional
// 2-bit branch history table (enable with `define BHT_EN).
module inst_fetch #(
  parameter int          BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_data,
  output logic        to_decoder,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        predict,
  input  logic        dec_accept,
  input  logic [31:0] dec_next_pc,
  input  logic        jalr_done,
  input  logic [31:0] jalr_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_update,
  input  logic [31:0] br_pc,
  input  logic        br_taken
);
  typedef enum logic [1:0] {REQ, HOLD, JWAIT, DROP} state_t;
  state_t state, state_nxt;
  logic [31:0] pc_reg, drop_addr;
  logic is_jalr, take, unused;
  assign is_jalr = inst[6:0] == 7'b1100111 ||
                   (inst[1:0] == 2'b10 && inst[15:13] == 3'b100 && inst[11:7] != 5'd0 && inst[6:2] == 5'd0);
  assign take = state == REQ && icache_valid && !flush;
  assign unused = ^{br_update, br_pc, br_taken};
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= REQ;
    else if (rdy_in) state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (flush)
      state_nxt = ((state == REQ || state == DROP) && !icache_valid) ? DROP : REQ;
    else
      case (state)
        REQ:   state_nxt = icache_valid ? HOLD : REQ;
        HOLD:  state_nxt = dec_accept ? (is_jalr ? JWAIT : REQ) : HOLD;
        JWAIT: state_nxt = jalr_done ? REQ : JWAIT;
        DROP:  state_nxt = icache_valid ? REQ : DROP;
      endcase
  end
  always_comb begin
    icache_req  = rst_in && (state == REQ || state == DROP);
    icache_addr = state == DROP ? drop_addr : pc_reg;
    to_decoder  = rst_in && state == HOLD;
  end
  // drop_addr keeps the abandoned request's address stable until its response arrives
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_reg    <= RESET_PC;
      drop_addr <= RESET_PC;
      inst      <= 32'h0;
      pc        <= 32'h0;
    end else if (rdy_in) begin
      if (flush) begin
        pc_reg <= flush_pc;
        if (state == REQ && !icache_valid) drop_addr <= pc_reg;
      end else begin
        if (take) begin
          inst <= icache_data;
          pc   <= pc_reg;
        end
        if (state == HOLD && dec_accept && !is_jalr) pc_reg <= dec_next_pc;
        if (state == JWAIT && jalr_done) pc_reg <= jalr_target;
      end
    end
  end
`ifdef BHT_EN
  logic [1:0] bht [2**BHT_BITS];
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 2**BHT_BITS; i++) bht[i] <= 2'b01;
      predict <= 1'b0;
    end else if (rdy_in) begin
      if (br_update)
        bht[br_pc[BHT_BITS:1]] <= br_taken ? (bht[br_pc[BHT_BITS:1]] == 2'b11 ? 2'b11 : bht[br_pc[BHT_BITS:1]] + 2'd1)
                                           : (bht[br_pc[BHT_BITS:1]] == 2'b00 ? 2'b00 : bht[br_pc[BHT_BITS:1]] - 2'd1);
      if (take) predict <= bht[pc_reg[BHT_BITS:1]][1];
    end
  end
`else
  assign predict = 1'b0;
`endif
endmodule
